// File: rtl/nasti_read_burst_splitter_if.sv
// NASTI read-channel bundle (AR + R) shared by both sides of the burst splitter.
// The master modport is the initiator (drives AR, receives R); slave is the target.
interface nasti_read_burst_splitter_if #(
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned USER_WIDTH = 1
);
  logic [ID_WIDTH-1:0]   ar_id;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]            ar_len;
  logic [2:0]            ar_size;
  logic [1:0]            ar_burst;
  logic                  ar_lock;
  logic [3:0]            ar_cache;
  logic [2:0]            ar_prot;
  logic [3:0]            ar_qos;
  logic [3:0]            ar_region;
  logic [USER_WIDTH-1:0] ar_user;
  logic                  ar_valid;
  logic                  ar_ready;

  logic [ID_WIDTH-1:0]   r_id;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;
  logic                  r_last;
  logic [USER_WIDTH-1:0] r_user;
  logic                  r_valid;
  logic                  r_ready;

  modport master (
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/nasti_read_burst_splitter.sv
// Splits one NASTI read burst into INCR sub-bursts of at most MAX_BEATS beats
// and stitches the returned R beats back into a single burst upstream.
// "master" is the upstream-facing port (this block is its target);
// "slave" is the port toward the narrower reader (this block initiates).
module nasti_read_burst_splitter #(
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned MAX_BEATS  = 8
) (
  input logic                         clk,
  input logic                         rst,
  nasti_read_burst_splitter_if.slave  master,
  nasti_read_burst_splitter_if.master slave
);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R} state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [8:0] MAX_B      = 9'(MAX_BEATS);

  state_t state, state_nxt;

  logic [ID_WIDTH-1:0]   req_id;
  logic [7:0]            req_len;
  logic [2:0]            req_size;
  logic [1:0]            req_burst;
  logic                  req_lock;
  logic [3:0]            req_cache;
  logic [2:0]            req_prot;
  logic [3:0]            req_qos;
  logic [3:0]            req_region;
  logic [USER_WIDTH-1:0] req_user;

  logic [8:0]            rem;
  logic [ADDR_WIDTH-1:0] cur_addr;

  logic [8:0]            sub_beats;
  logic [7:0]            sub_len;
  logic [ADDR_WIDTH-1:0] next_addr;

  // Size the current sub-burst and the address of the one after it.
  // Non-INCR bursts go out whole with their original length.
  always_comb begin
    if (req_burst != BURST_INCR) begin
      sub_beats = {1'b0, req_len} + 9'd1;
    end else if (rem > MAX_B) begin
      sub_beats = MAX_B;
    end else begin
      sub_beats = rem;
    end
    sub_len   = sub_beats[7:0] - 8'd1;
    next_addr = ((cur_addr >> req_size) << req_size)
              + (ADDR_WIDTH'(sub_beats) << req_size);
  end

  // Next-state logic and handshake outputs; everything is held low in reset.
  always_comb begin
    state_nxt       = state;
    master.ar_ready = 1'b0;
    slave.ar_valid  = 1'b0;
    master.r_valid  = 1'b0;
    slave.r_ready   = 1'b0;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          master.ar_ready = 1'b1;
          if (master.ar_valid) state_nxt = S_AR;
        end
        S_AR: begin
          slave.ar_valid = 1'b1;
          if (slave.ar_ready) state_nxt = S_R;
        end
        S_R: begin
          master.r_valid = slave.r_valid;
          slave.r_ready  = master.r_ready;
          if (slave.r_valid && master.r_ready && slave.r_last) begin
            state_nxt = (rem == 9'd0) ? S_IDLE : S_AR;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // State register, request latch and remaining-beat / address bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      req_id     <= '0;
      req_len    <= '0;
      req_size   <= '0;
      req_burst  <= '0;
      req_lock   <= '0;
      req_cache  <= '0;
      req_prot   <= '0;
      req_qos    <= '0;
      req_region <= '0;
      req_user   <= '0;
      rem        <= '0;
      cur_addr   <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && master.ar_valid) begin
        req_id     <= master.ar_id;
        req_len    <= master.ar_len;
        req_size   <= master.ar_size;
        req_burst  <= master.ar_burst;
        req_lock   <= master.ar_lock;
        req_cache  <= master.ar_cache;
        req_prot   <= master.ar_prot;
        req_qos    <= master.ar_qos;
        req_region <= master.ar_region;
        req_user   <= master.ar_user;
        cur_addr   <= master.ar_addr;
        rem        <= (master.ar_burst == BURST_INCR) ? ({1'b0, master.ar_len} + 9'd1) : '0;
      end
      if (state == S_AR && slave.ar_ready) begin
        if (req_burst == BURST_INCR) rem <= rem - sub_beats;
        cur_addr <= next_addr;
      end
    end
  end

  // Sub-burst request toward the narrower side.
  assign slave.ar_id     = req_id;
  assign slave.ar_addr   = cur_addr;
  assign slave.ar_len    = sub_len;
  assign slave.ar_size   = req_size;
  assign slave.ar_burst  = req_burst;
  assign slave.ar_lock   = req_lock;
  assign slave.ar_cache  = req_cache;
  assign slave.ar_prot   = req_prot;
  assign slave.ar_qos    = req_qos;
  assign slave.ar_region = req_region;
  assign slave.ar_user   = req_user;

  // R pass-through; only the last beat of the last sub-burst is marked last.
  assign master.r_id   = req_id;
  assign master.r_data = slave.r_data;
  assign master.r_resp = slave.r_resp;
  assign master.r_user = slave.r_user;
  assign master.r_last = slave.r_last && (rem == 9'd0);

endmodule

// File: tb/tb_nasti_read_burst_splitter.sv
// Bench for nasti_read_burst_splitter: directed cases followed by random bursts,
// with a slave-side responder and a reference plan of expected sub-bursts.
module tb_nasti_read_burst_splitter;

  localparam int unsigned IDW = 2;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 64;
  localparam int unsigned UW  = 1;
  localparam int unsigned MAXB = 8;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [0:0]  user;
  } req_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } sub_t;

  logic clk;
  logic rst;

  nasti_read_burst_splitter_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) m_if ();
  nasti_read_burst_splitter_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) s_if ();

  nasti_read_burst_splitter #(
    .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW), .MAX_BEATS(MAXB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .master(m_if),
    .slave(s_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Shared reference state
  req_t cur_req;
  sub_t exp_ar[$];
  sub_t seen_ar[$];
  int   exp_total;
  int   n_planned;
  int   mbeats;
  int   ar_seen;
  bit   done;
  bit   stall_en;

  // Reference plan: split [addr, len+1 beats) into chunks of <= MAXB beats;
  // every chunk after the first starts on a size-aligned address.
  function automatic void plan(input req_t r);
    int unsigned left;
    logic [31:0] a;
    logic [31:0] mask;
    exp_ar.delete();
    if (r.burst != 2'b01) begin
      exp_ar.push_back('{addr: r.addr, len: r.len});
    end else begin
      left = int'(r.len) + 1;
      a    = r.addr;
      mask = ~((32'd1 << r.size) - 32'd1);
      while (left > 0) begin
        int unsigned n;
        n = (left > MAXB) ? MAXB : left;
        exp_ar.push_back('{addr: a, len: 8'(n - 1)});
        a = (a & mask) + 32'(n * (32'd1 << r.size));
        left -= n;
      end
    end
    exp_total = int'(r.len) + 1;
    n_planned = exp_ar.size();
  endfunction

  // Slave responder and R-path monitor
  logic        s_rv;
  logic [63:0] s_data;
  logic [1:0]  s_resp;
  logic [0:0]  s_user;
  logic        s_rlast;
  logic [1:0]  s_rid;
  logic        s_arr;
  logic        m_rr;
  int          owed;
  bit          in_r;
  bit          stall_prev;
  logic [63:0] held_ar;

  initial begin
    s_rv = 0; s_data = '0; s_resp = '0; s_user = '0; s_rlast = 0; s_rid = '0;
    s_arr = 1; m_rr = 1; owed = 0; in_r = 0; stall_prev = 0; held_ar = '0;
    s_if.ar_ready = 1; s_if.r_valid = 0; s_if.r_data = '0; s_if.r_resp = '0;
    s_if.r_user = '0; s_if.r_last = 0; s_if.r_id = '0; m_if.r_ready = 1;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_r = 0; owed = 0; s_rv = 0; stall_prev = 0;
      end else begin
        check("r_valid_passthru", m_if.r_valid, (in_r ? s_rv : 1'b0));
        check("r_ready_passthru", s_if.r_ready, (in_r ? m_rr : 1'b0));
        if (m_if.r_valid && m_if.r_ready) begin
          check("r_data", m_if.r_data, s_data);
          check("r_resp", m_if.r_resp, s_resp);
          check("r_user", m_if.r_user, s_user);
          check("r_id", m_if.r_id, cur_req.id);
          check("r_last", m_if.r_last, (mbeats + 1 == exp_total));
          mbeats++;
          if (mbeats == exp_total) done = 1;
        end
        if (in_r && s_rv && m_rr) begin
          owed--;
          s_rv = 0;
          if (s_rlast) in_r = 0;
        end
        if (stall_prev) begin
          check("ar_valid_held", s_if.ar_valid, 1'b1);
          check("ar_fields_held",
                {s_if.ar_id, s_if.ar_addr, s_if.ar_len, s_if.ar_size, s_if.ar_burst, s_if.ar_lock,
                 s_if.ar_cache, s_if.ar_prot, s_if.ar_qos, s_if.ar_region, s_if.ar_user}, held_ar);
        end
        if (s_if.ar_valid && s_arr) begin
          check("ar_expected_present", (exp_ar.size() > 0), 1'b1);
          if (exp_ar.size() > 0) begin
            sub_t e;
            e = exp_ar.pop_front();
            check("ar_addr", s_if.ar_addr, e.addr);
            check("ar_len", s_if.ar_len, e.len);
          end
          check("ar_attrs",
                {s_if.ar_id, s_if.ar_size, s_if.ar_burst, s_if.ar_lock, s_if.ar_cache,
                 s_if.ar_prot, s_if.ar_qos, s_if.ar_region, s_if.ar_user},
                {cur_req.id, cur_req.size, cur_req.burst, cur_req.lock, cur_req.cache,
                 cur_req.prot, cur_req.qos, cur_req.region, cur_req.user});
          seen_ar.push_back('{addr: s_if.ar_addr, len: s_if.ar_len});
          ar_seen++;
          owed = int'(s_if.ar_len) + 1;
          s_rid = s_if.ar_id;
          in_r = 1;
        end
        stall_prev = s_if.ar_valid && !s_arr;
        held_ar = {s_if.ar_id, s_if.ar_addr, s_if.ar_len, s_if.ar_size, s_if.ar_burst, s_if.ar_lock,
                   s_if.ar_cache, s_if.ar_prot, s_if.ar_qos, s_if.ar_region, s_if.ar_user};
      end
      @(posedge clk);
      #1;
      s_arr = stall_en ? ($urandom_range(0, 2) == 0) : 1'b1;
      m_rr  = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (!s_rv && in_r && owed > 0 && (!stall_en || $urandom_range(0, 3) != 0)) begin
        s_rv    = 1;
        s_data  = {$urandom, $urandom};
        s_resp  = 2'($urandom_range(0, 3));
        s_user  = 1'($urandom_range(0, 1));
        s_rlast = (owed == 1);
      end
      s_if.ar_ready = s_arr;
      m_if.r_ready  = m_rr;
      s_if.r_valid  = s_rv;
      s_if.r_data   = s_data;
      s_if.r_resp   = s_resp;
      s_if.r_user   = s_user;
      s_if.r_last   = s_rlast;
      s_if.r_id     = s_rid;
    end
  end

  function automatic req_t mk_req(input logic [31:0] addr, input logic [7:0] len,
                                  input logic [2:0] size, input logic [1:0] burst);
    req_t r;
    r.id = 2'($urandom_range(0, 3)); r.addr = addr; r.len = len; r.size = size; r.burst = burst;
    r.lock = 1'($urandom_range(0, 1)); r.cache = 4'($urandom_range(0, 15));
    r.prot = 3'($urandom_range(0, 7)); r.qos = 4'($urandom_range(0, 15));
    r.region = 4'($urandom_range(0, 15)); r.user = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic start_txn(input req_t r, input string tag);
    int unsigned k;
    cur_req = r;
    plan(r);
    mbeats = 0; ar_seen = 0; done = 0;
    seen_ar.delete();
    @(posedge clk); #1;
    m_if.ar_id = r.id; m_if.ar_addr = r.addr; m_if.ar_len = r.len; m_if.ar_size = r.size;
    m_if.ar_burst = r.burst; m_if.ar_lock = r.lock; m_if.ar_cache = r.cache; m_if.ar_prot = r.prot;
    m_if.ar_qos = r.qos; m_if.ar_region = r.region; m_if.ar_user = r.user; m_if.ar_valid = 1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!m_if.ar_ready && k < 100);
    check({tag, " ar_accept"}, m_if.ar_ready, 1'b1);
    @(posedge clk); #1;
    m_if.ar_valid = 0;
    // Scramble the upstream fields so an unlatched request would show up.
    m_if.ar_addr = $urandom; m_if.ar_len = 8'($urandom); m_if.ar_id = 2'($urandom);
    m_if.ar_size = 3'($urandom); m_if.ar_burst = 2'($urandom); m_if.ar_cache = 4'($urandom);
  endtask

  task automatic wait_done(input string tag);
    int unsigned k;
    k = 0;
    while (!done && k < 4000) begin
      @(negedge clk);
      k++;
    end
    check({tag, " done"}, done, 1'b1);
    check({tag, " beat_count"}, mbeats, exp_total);
    check({tag, " ar_count"}, ar_seen, n_planned);
  endtask

  task automatic run_txn(input req_t r, input string tag);
    start_txn(r, tag);
    wait_done(tag);
  endtask

  initial begin
    req_t r;
    int unsigned k;
    rst = 1; stall_en = 0; done = 0; mbeats = 0; ar_seen = 0; exp_total = 0; n_planned = 0;
    m_if.ar_valid = 0; m_if.ar_id = '0; m_if.ar_addr = '0; m_if.ar_len = '0; m_if.ar_size = '0;
    m_if.ar_burst = '0; m_if.ar_lock = 0; m_if.ar_cache = '0; m_if.ar_prot = '0; m_if.ar_qos = '0;
    m_if.ar_region = '0; m_if.ar_user = '0;
    cur_req = mk_req(32'h0, 8'h0, 3'd0, 2'b01);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst ar_ready", m_if.ar_ready, 1'b0);
    check("rst slave_ar_valid", s_if.ar_valid, 1'b0);
    check("rst r_valid", m_if.r_valid, 1'b0);
    check("rst slave_r_ready", s_if.r_ready, 1'b0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("post_rst ar_ready", m_if.ar_ready, 1'b1);
    check("post_rst slave_ar_valid", s_if.ar_valid, 1'b0);

    // T1: 20 beats -> 8 + 8 + 4
    run_txn(mk_req(32'h1000, 8'd19, 3'd3, 2'b01), "T1");
    check("T1 n_ar", seen_ar.size(), 3);
    if (seen_ar.size() == 3) begin
      check("T1 ar0", {seen_ar[0].addr, seen_ar[0].len}, {32'h1000, 8'd7});
      check("T1 ar1", {seen_ar[1].addr, seen_ar[1].len}, {32'h1040, 8'd7});
      check("T1 ar2", {seen_ar[2].addr, seen_ar[2].len}, {32'h1080, 8'd3});
    end

    // T2: exactly MAX_BEATS
    run_txn(mk_req(32'h2000, 8'd7, 3'd3, 2'b01), "T2");
    check("T2 n_ar", seen_ar.size(), 1);

    // T3: unaligned start, later sub-burst aligned
    run_txn(mk_req(32'h1004, 8'd8, 3'd3, 2'b01), "T3");
    check("T3 n_ar", seen_ar.size(), 2);
    if (seen_ar.size() == 2) begin
      check("T3 ar0", {seen_ar[0].addr, seen_ar[0].len}, {32'h1004, 8'd7});
      check("T3 ar1", {seen_ar[1].addr, seen_ar[1].len}, {32'h1040, 8'd0});
    end

    // T4: WRAP forwarded whole
    run_txn(mk_req(32'h30, 8'd15, 3'd3, 2'b10), "T4");
    check("T4 n_ar", seen_ar.size(), 1);
    if (seen_ar.size() == 1) check("T4 ar0", {seen_ar[0].addr, seen_ar[0].len}, {32'h30, 8'd15});

    // Address wrap at the top of the address space
    run_txn(mk_req(32'hFFFF_FFF8, 8'd9, 3'd3, 2'b01), "WRAPADDR");
    if (seen_ar.size() == 2) check("WRAPADDR ar1", seen_ar[1].addr, 32'h38);

    // Longest legal burst
    run_txn(mk_req(32'h8000, 8'd255, 3'd2, 2'b01), "LEN256");

    // T5: backpressure on T1
    stall_en = 1;
    run_txn(mk_req(32'h1000, 8'd19, 3'd3, 2'b01), "T5");
    stall_en = 0;

    // T6: reset during second sub-burst of T1
    start_txn(mk_req(32'h1000, 8'd19, 3'd3, 2'b01), "T6");
    k = 0;
    while (!(ar_seen >= 2 && mbeats >= 10) && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("T6 reached_2nd_sub", (ar_seen >= 2 && mbeats >= 10), 1'b1);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    check("T6 ar_ready", m_if.ar_ready, 1'b0);
    check("T6 slave_ar_valid", s_if.ar_valid, 1'b0);
    check("T6 r_valid", m_if.r_valid, 1'b0);
    check("T6 slave_r_ready", s_if.r_ready, 1'b0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("T6 post ar_ready", m_if.ar_ready, 1'b1);
    check("T6 post slave_ar_valid", s_if.ar_valid, 1'b0);
    run_txn(mk_req(32'h4000, 8'd3, 3'd3, 2'b01), "T6b");

    // Random bursts
    for (int i = 0; i < 10; i++) begin
      int unsigned kind;
      stall_en = ($urandom_range(0, 1) == 1);
      kind = $urandom_range(0, 5);
      if (kind == 0) begin
        logic [7:0] wl;
        wl = 8'((2 << $urandom_range(0, 3)) - 1);
        r = mk_req($urandom, wl, 3'($urandom_range(0, 3)), 2'b10);
      end else if (kind == 1) begin
        r = mk_req($urandom, 8'($urandom_range(0, 15)), 3'($urandom_range(0, 3)), 2'b00);
      end else begin
        r = mk_req($urandom, 8'($urandom_range(0, 40)), 3'($urandom_range(0, 3)), 2'b01);
      end
      run_txn(r, "RAND");
    end
    stall_en = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
